// File: rtl/mem_writeback_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage and the data memory.
// The stage is the master; the memory model or controller is the slave.
interface mem_writeback_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_writeback.sv
// MIPS memory/write-back stage: runs loads and stores over a req/ack bus with byte lanes,
// stalls the pipeline while an access is pending, and registers the register-file write port.
module mem_writeback #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_m,
    input  logic [31:0]            alu_result_m,
    input  logic [31:0]            write_data_m,
    input  logic                   reg_we_m,
    input  logic                   mem_to_reg_m,
    input  logic                   mem_we_m,
    input  logic [1:0]             mem_size_m,
    input  logic                   mem_unsigned_m,
    input  logic [4:0]             reg_write_addr_m,
    mem_writeback_if.master        dmem,
    output logic                   stall_m,
    output logic                   reg_we_w,
    output logic [4:0]             reg_write_addr_w,
    output logic [31:0]            reg_write_data_w,
    output logic                   addr_err_w,
    output logic                   bus_err_w
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               regWe_q, regWe_d;
    logic [4:0]         regAddr_q, regAddr_d;
    logic [31:0]        regData_q, regData_d;
    logic               addrErr_q, addrErr_d;
    logic               busErr_q, busErr_d;

    logic [1:0]         off;
    logic               isByte, isHalf, isWord;
    logic               memOp, misaligned, writesReg, timedOut;
    logic [7:0]         loadByte;
    logic [15:0]        loadHalf;
    logic [31:0]        loadData;
    logic [31:0]        storeData;
    logic [3:0]         storeBe;

    assign off        = alu_result_m[1:0];
    assign isByte     = (mem_size_m == 2'b00);
    assign isHalf     = (mem_size_m == 2'b01);
    assign isWord     = mem_size_m[1];
    assign memOp      = valid_m & (mem_to_reg_m | mem_we_m);
    assign misaligned = (isHalf & off[0]) | (isWord & (off != 2'b00));
    assign writesReg  = valid_m & reg_we_m & (reg_write_addr_m != 5'd0);
    assign timedOut   = (timer_q == TMR_W'(TIMEOUT - 1));

    // The M-stage inputs are frozen by stall_m, so the bus fields stay stable until ack.
    assign dmem.dmem_we    = mem_we_m;
    assign dmem.dmem_addr  = {alu_result_m[31:2], 2'b00};
    assign dmem.dmem_wdata = storeData;
    assign dmem.dmem_be    = storeBe;

    always_comb begin
        storeData = write_data_m;
        storeBe   = 4'b1111;
        if (isByte) begin
            storeData = {4{write_data_m[7:0]}};
            storeBe   = 4'b0001 << off;
        end else if (isHalf) begin
            storeData = {2{write_data_m[15:0]}};
            storeBe   = off[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        case (off)
            2'd0:    loadByte = dmem.dmem_rdata[7:0];
            2'd1:    loadByte = dmem.dmem_rdata[15:8];
            2'd2:    loadByte = dmem.dmem_rdata[23:16];
            default: loadByte = dmem.dmem_rdata[31:24];
        endcase
        loadHalf = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        if (isByte) begin
            loadData = {{24{~mem_unsigned_m & loadByte[7]}}, loadByte};
        end else if (isHalf) begin
            loadData = {{16{~mem_unsigned_m & loadHalf[15]}}, loadHalf};
        end else begin
            loadData = dmem.dmem_rdata;
        end
    end

    // W registers default to a bubble; only a finished instruction leaves IDLE/ACCESS with a write.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        regWe_d       = 1'b0;
        regAddr_d     = reg_write_addr_m;
        regData_d     = alu_result_m;
        addrErr_d     = 1'b0;
        busErr_d      = 1'b0;
        stall_m       = 1'b0;
        dmem.dmem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (memOp) begin
                    if (misaligned) begin
                        addrErr_d = 1'b1;
                    end else begin
                        stall_m = 1'b1;
                        state_d = ACCESS;
                        timer_d = '0;
                    end
                end else begin
                    regWe_d = writesReg;
                end
            end
            ACCESS: begin
                dmem.dmem_req = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d = IDLE;
                    if (mem_to_reg_m) begin
                        regWe_d   = writesReg;
                        regData_d = loadData;
                    end
                end else if (timedOut) begin
                    state_d  = IDLE;
                    busErr_d = 1'b1;
                end else begin
                    stall_m = 1'b1;
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            regWe_q   <= 1'b0;
            regAddr_q <= 5'd0;
            regData_q <= 32'd0;
            addrErr_q <= 1'b0;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            regWe_q   <= regWe_d;
            regAddr_q <= regAddr_d;
            regData_q <= regData_d;
            addrErr_q <= addrErr_d;
            busErr_q  <= busErr_d;
        end
    end

    assign reg_we_w         = regWe_q;
    assign reg_write_addr_w = regAddr_q;
    assign reg_write_data_w = regData_q;
    assign addr_err_w       = addrErr_q;
    assign bus_err_w        = busErr_q;

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Memory/write-back stage of the 5-stage MIPS pipeline.
- Takes the M-stage instruction and runs its data-memory access through a req/ack handshake, with byte/half/word lane handling.
- Registers the result into the W stage and drives the register-file write port (reg_we_w, reg_write_addr_w, reg_write_data_w) that the decode stage consumes.
- Raises stall_m to the hazard unit while a memory access is outstanding.

Parameters:
TIMEOUT, 64, max cycles spent waiting for dmem_ack before the access is aborted with bus_err_w
TMR_W, 7, counter width, must satisfy 2**TMR_W > TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
valid_m  in  1  M-stage slot holds a real instruction
alu_result_m  in  32  ALU result / effective address
write_data_m  in  32  store data (rt)
reg_we_m  in  1  instruction writes a register
mem_to_reg_m  in  1  instruction is a load
mem_we_m  in  1  instruction is a store
mem_size_m  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned_m  in  1  zero-extend load (lbu/lhu)
reg_write_addr_m  in  5  destination register
dmem_req  out  1  memory request valid
dmem_we  out  1  1 store, 0 load
dmem_addr  out  32  word-aligned address {alu_result_m[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  memory completes request this cycle
dmem_rdata  in  32  load data, valid with dmem_ack
stall_m  out  1  freeze F/D/E/M pipeline registers
reg_we_w  out  1  register-file write enable
reg_write_addr_w  out  5  register-file write address
reg_write_data_w  out  32  register-file write data
addr_err_w  out  1  misaligned access, one-cycle pulse
bus_err_w  out  1  access timed out, one-cycle pulse

Behaviour:
- Reset: state IDLE, timer 0.
  - All W outputs, addr_err_w, bus_err_w and dmem_req are 0.
  - Asserting rst mid-access drops dmem_req at that edge; a later dmem_ack in IDLE is ignored.
- mem_op = valid_m & (mem_to_reg_m | mem_we_m).
- misaligned = (size half & addr[0]) | (size word & addr[1:0]!=0).
- State IDLE:
  - Non-memory op, or valid_m=0: W registers load at the next edge (latency 1).
  - reg_we_w = valid_m & reg_we_m & (reg_write_addr_m != 0); reg_write_data_w = alu_result_m.
  - mem_op & misaligned: no request. Next edge gives addr_err_w=1 and reg_we_w=0; stall_m stays 0.
  - mem_op & aligned: stall_m=1 combinationally; next state ACCESS, timer cleared; reg_we_w=0 that edge (bubble).
- State ACCESS:
  - dmem_req=1, with dmem_we/addr/wdata/be held stable from the stalled M inputs until ack.
  - stall_m = ~dmem_ack, so the pipeline advances on the ack cycle.
  - On dmem_ack: next state IDLE.
    - Load: W registers load extracted data with reg_we_w per the $0 rule above.
    - Store: reg_we_w=0.
  - No ack: timer increments. On the cycle timer == TIMEOUT-1 without ack:
    - dmem_req drops, state goes IDLE, stall_m=0 that cycle.
    - Next edge gives bus_err_w=1 and reg_we_w=0.
    - A late ack is ignored.
  - Ack and timeout in the same cycle: ack wins.
- Store lanes (little-endian, off = addr[1:0]):
  - Byte: wdata={4{wd[7:0]}}, be=4'b0001<<off.
  - Half: wdata={2{wd[15:0]}}, be=addr[1]?1100:0011.
  - Word: wdata=wd, be=1111.
- Load extract: shifted = rdata >> (8*off).
  - Byte: shifted[7:0], sign- or zero-extended per mem_unsigned_m.
  - Half: shifted[15:0], sign- or zero-extended per mem_unsigned_m.
  - Word: rdata.
- Error pulses last exactly one cycle. A non-memory instruction never produces dmem_req.
- dmem_ack while dmem_req=0 has no effect.

Test Plan:
- ALU op: alu_result_m=0x0000_1234, reg_we_m=1, addr 5, no mem -> next cycle reg_we_w=1, addr_w=5, data_w=0x1234, stall_m=0, dmem_req never 1.
- lb addr 0x103 with dmem_rdata=0x80AB_CDEF, ack 3 cycles after req -> stall_m high until the ack cycle, dmem_addr=0x100; W data=0xFFFF_FF80. Repeat as lbu -> 0x0000_0080.
- sh addr 0x202, wd=0x0000_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF; after ack reg_we_w=0.
- lw addr 0x006 -> no dmem_req; addr_err_w=1 for one cycle, reg_we_w=0, stall_m=0. Write to $0 (ALU op, addr 0) -> reg_we_w=0.
- Load, ack never arrives, TIMEOUT=64 -> dmem_req high 64 cycles then low; bus_err_w pulses once; stall_m released. A later ack is ignored.
- Reset asserted on the 2nd ACCESS cycle -> next cycle dmem_req=0, stall_m=0, all W outputs 0; a following ALU op completes normally.
